// File: rtl/mda_pwm_capture.sv
// PWM capture: synchronizes pwm_in and measures period and high time in clk cycles.
// Adds a stuck-line timeout that reports the line level and forces the FSM back to IDLE.
//
// state | meaning
// IDLE  | waiting for the first rise; any partial period is discarded
// HIGH  | line high since the last rise; cnt counts from that rise
// LOW   | line low after a fall; the next rise closes the period
module mda_pwm_capture #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pwm_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] duty_cycle,
  output logic                   valid,
  output logic                   timeout,
  output logic                   stuck_high
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [COUNT_WIDTH-1:0] TO_CNT  = COUNT_WIDTH'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 state;
  logic                   sync1;
  logic                   s;
  logic                   s_d;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] high_len;
  logic                   rise;
  logic                   fall;
  logic                   to_hit;

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  // An edge in the same cycle as the terminal count wins over the timeout.
  assign to_hit = (state != IDLE) && (cnt == TO_CNT) && !rise && !fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      s          <= 1'b0;
      s_d        <= 1'b0;
      cnt        <= '0;
      high_len   <= '0;
      state      <= IDLE;
      period     <= '0;
      duty_cycle <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      s_d   <= s;
      valid <= 1'b0;

      if (rise) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            high_len <= cnt;
            state    <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            period     <= cnt;
            duty_cycle <= high_len;
            valid      <= 1'b1;
            timeout    <= 1'b0;
            state      <= HIGH;
          end
        end
        default: state <= IDLE;
      endcase

      // to_hit excludes edges, so this never collides with the case above.
      if (to_hit) begin
        timeout    <= 1'b1;
        stuck_high <= s;
        period     <= '0;
        duty_cycle <= '0;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mda_pwm_capture.sv
// Bench for mda_pwm_capture: table-driven waveform rows, hand-written corner sequences,
// and a timestamp-based reference model compared every cycle.
module tb_mda_pwm_capture;

  localparam int W  = 16;
  localparam int TO = 1200;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] duty_cycle;
  logic         valid;
  logic         timeout;
  logic         stuck_high;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mda_pwm_capture #(.COUNT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .period     (period),
    .duty_cycle (duty_cycle),
    .valid      (valid),
    .timeout    (timeout),
    .stuck_high (stuck_high)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks sample timestamps of the last rise and fall.
  typedef struct packed {
    logic         v;
    logic [W-1:0] p;
    logic [W-1:0] d;
    logic         t;
    logic         s;
  } exp_t;

  localparam int PH_NONE = 0;
  localparam int PH_HI   = 1;
  localparam int PH_LO   = 2;

  exp_t cur, e0, e1, e2;
  int   tick = 0;
  int   m_r = 0;
  int   m_f = 0;
  int   m_phase = PH_NONE;
  logic m_prev = 1'b0;
  bit   armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      cur = '0; e0 = '0; e1 = '0; e2 = '0;
      m_phase = PH_NONE;
      m_prev  = 1'b0;
      armed   = 1'b1;
    end else begin
      cur.v = 1'b0;
      if (pwm_in && !m_prev) begin
        if (m_phase == PH_LO) begin
          cur.p = W'(tick - m_r);
          cur.d = W'(m_f - m_r);
          cur.v = 1'b1;
          cur.t = 1'b0;
        end
        m_phase = PH_HI;
        m_r     = tick;
      end else if (!pwm_in && m_prev) begin
        if (m_phase == PH_HI) begin
          m_phase = PH_LO;
          m_f     = tick;
        end
      end else if (m_phase != PH_NONE && (tick - m_r) == TO) begin
        cur.t   = 1'b1;
        cur.s   = pwm_in;
        cur.p   = '0;
        cur.d   = '0;
        m_phase = PH_NONE;
      end
      m_prev = pwm_in;
      // Two-stage synchronizer delay between a sample and the registered result.
      e2 = e1; e1 = e0; e0 = cur;
    end
    tick++;
  end

  typedef struct {int p; int d;} meas_t;
  meas_t vq[$];
  logic  valid_q = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      chk("model_valid",   int'(valid),      int'(e2.v));
      chk("model_period",  int'(period),     int'(e2.p));
      chk("model_duty",    int'(duty_cycle), int'(e2.d));
      chk("model_timeout", int'(timeout),    int'(e2.t));
      chk("model_stuck",   int'(stuck_high), int'(e2.s));
      chk("valid_back_to_back", int'(valid && valid_q), 0);
      if (valid) vq.push_back('{int'(period), int'(duty_cycle)});
      valid_q = valid;
    end
  end

  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_duty;
  } row_t;

  row_t rows[9];

  initial begin
    int k;

    rows[0] = '{300, 700, 3, 1000, 300};
    rows[1] = '{ 50, 150, 4,  200,  50};
    rows[2] = '{  1,   1, 6,    2,   1};
    rows[3] = '{  1,   4, 4,    5,   1};
    rows[4] = '{  7,   1, 4,    8,   7};
    rows[5] = '{ 30,  70, 3,  100,  30};
    for (int i = 6; i < 9; i++) begin
      rows[i].hi         = int'($urandom_range(1, 400));
      rows[i].lo         = int'($urandom_range(1, 600));
      rows[i].reps       = 3;
      rows[i].exp_period = rows[i].hi + rows[i].lo;
      rows[i].exp_duty   = rows[i].hi;
    end

    @(negedge clk);
    @(negedge clk);
    chk("reset_period",  int'(period),     0);
    chk("reset_duty",    int'(duty_cycle), 0);
    chk("reset_valid",   int'(valid),      0);
    chk("reset_timeout", int'(timeout),    0);
    reset = 1'b0;
    hold(1'b0, 5);
    vq.delete();

    // Rows back to back; every period of every row is closed by the following rise.
    for (int i = 0; i < 9; i++) begin
      repeat (rows[i].reps) begin
        hold(1'b1, rows[i].hi);
        hold(1'b0, rows[i].lo);
      end
    end
    hold(1'b1, 5);
    k = 0;
    for (int i = 0; i < 9; i++) k += rows[i].reps;
    chk("rows_valid_count", vq.size(), k);
    k = 0;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < rows[i].reps; j++) begin
        if (k < vq.size()) begin
          chk("rows_period", vq[k].p, rows[i].exp_period);
          chk("rows_duty",   vq[k].d, rows[i].exp_duty);
        end
        k++;
      end
    end
    chk("rows_timeout", int'(timeout), 0);

    // Random burst, model-checked only.
    repeat (40) begin
      hold(1'b1, int'($urandom_range(1, 80)));
      hold(1'b0, int'($urandom_range(1, 80)));
    end

    // Stuck low.
    hold(1'b0, 1300);
    chk("stuck_low_timeout", int'(timeout),    1);
    chk("stuck_low_level",   int'(stuck_high), 0);
    chk("stuck_low_period",  int'(period),     0);
    chk("stuck_low_duty",    int'(duty_cycle), 0);

    // Recovery: first period after timeout gives no valid, the next one does.
    hold(1'b1, 30);
    hold(1'b0, 70);
    chk("recover_timeout_held", int'(timeout), 1);
    hold(1'b1, 30);
    hold(1'b0, 70);
    chk("recover_timeout_clear", int'(timeout),    0);
    chk("recover_period",        int'(period),     100);
    chk("recover_duty",          int'(duty_cycle), 30);

    // Stuck high.
    hold(1'b1, 1300);
    chk("stuck_high_timeout", int'(timeout),    1);
    chk("stuck_high_level",   int'(stuck_high), 1);
    chk("stuck_high_period",  int'(period),     0);

    // Reset in the middle of a high phase.
    hold(1'b0, 50);
    hold(1'b1, 10);
    do_reset();
    chk("midreset_valid",   int'(valid),      0);
    chk("midreset_period",  int'(period),     0);
    chk("midreset_duty",    int'(duty_cycle), 0);
    chk("midreset_timeout", int'(timeout),    0);
    chk("midreset_stuck",   int'(stuck_high), 0);
    hold(1'b1, 20);
    hold(1'b0, 70);
    repeat (3) begin
      hold(1'b1, 30);
      hold(1'b0, 70);
    end
    hold(1'b1, 5);
    chk("midreset_after_period", int'(period),     100);
    chk("midreset_after_duty",   int'(duty_cycle), 30);

    // Line high out of reset, then fastest toggling.
    pwm_in = 1'b1;
    do_reset();
    hold(1'b1, 10);
    for (int j = 0; j < 20; j++) hold(logic'(j % 2), 1);
    vq.delete();
    for (int j = 20; j < 30; j++) hold(logic'(j % 2), 1);
    chk("fast_valid_count", vq.size(), 5);
    foreach (vq[j]) begin
      chk("fast_period", vq[j].p, 2);
      chk("fast_duty",   vq[j].d, 1);
    end

    // Rise arriving exactly at the terminal count.
    pwm_in = 1'b0;
    do_reset();
    hold(1'b0, 5);
    vq.delete();
    repeat (4) begin
      hold(1'b1, 400);
      hold(1'b0, TO - 400);
    end
    hold(1'b1, 5);
    chk("edge_at_to_count", vq.size(), 4);
    foreach (vq[j]) begin
      chk("edge_at_to_period", vq[j].p, TO);
      chk("edge_at_to_duty",   vq[j].d, 400);
    end
    chk("edge_at_to_timeout", int'(timeout), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
